i2c_rx_byte_controller: RTL and testbench

//  I2C master-side byte receiver. This is the read-direction counterpart of the master byte transmitter.
//  - Clocks 8 data bits in from the slave, MSB first, then drives ACK or NACK on the 9th SCL pulse.
//  - Runs on a shared quarter-bit tick. Honours clock stretching and aborts on a stretch timeout.
//  - Sits under the I2C master sequencer, which owns START/STOP generation and the mux of the open-drain lines.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_rx_byte_controller_if.sv | 32 +++
 rtl/i2c_scl_stretch_monitor.sv | 35 +++
 rtl/i2c_rx_byte_controller.sv | 140 ++++++++++++++
 tb/tb_i2c_rx_byte_controller.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C master byte controllers (TX and RX).
// Quarter-bit step names and the receive-side FSM states live here.
package i2c_pkg;

  // One SCL period is split into four quarter-bit steps.
  typedef enum logic [1:0] {
    STEP_RISE = 2'd0,
    STEP_HIGH = 2'd1,
    STEP_FALL = 2'd2,
    STEP_LOW  = 2'd3
  } step_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } rx_state_e;

  localparam int unsigned BITS_PER_BYTE = 8;

  // SCL is released for every step except the low quarter.
  function automatic logic scl_released(step_e s);
    return s != STEP_LOW;
  endfunction

endpackage

// File: rtl/i2c_rx_byte_controller_if.sv
// Bundle between the I2C master sequencer and the byte receiver.
// master = sequencer side, slave = byte receiver side.
interface i2c_rx_byte_controller_if;

  logic       i_tick;
  logic       i_rx_start;
  logic       i_ack_send;
  logic       i_scl;
  logic       i_sda;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_done;
  logic       o_rx_error;
  logic       o_busy;
  logic       o_sda;
  logic       o_sda_disable;
  logic       o_scl;
  logic       o_scl_disable;

  modport master (
    output i_tick, i_rx_start, i_ack_send, i_scl, i_sda,
    input  o_rx_data, o_rx_valid, o_rx_done, o_rx_error, o_busy,
           o_sda, o_sda_disable, o_scl, o_scl_disable
  );

  modport slave (
    input  i_tick, i_rx_start, i_ack_send, i_scl, i_sda,
    output o_rx_data, o_rx_valid, o_rx_done, o_rx_error, o_busy,
           o_sda, o_sda_disable, o_scl, o_scl_disable
  );

endinterface

// File: rtl/i2c_scl_stretch_monitor.sv
// Counts quarter-bit ticks while a slave holds SCL low during the high
// phase and flags a timeout once STRETCH_TIMEOUT ticks have elapsed.
module i2c_scl_stretch_monitor #(
  parameter int unsigned STRETCH_TIMEOUT = 1024,
  parameter int unsigned TIMEOUT_W       = 11
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_active,
  input  logic i_clear,
  input  logic i_scl,
  output logic o_timeout
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(STRETCH_TIMEOUT);

  logic [TIMEOUT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values present before the clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clear || !i_active) begin
      cnt <= '0;
    end else if (i_tick && !i_scl && cnt != LIMIT) begin
      // Saturates at the limit so it can never wrap back past it.
      cnt <= cnt + TIMEOUT_W'(1);
    end
  end

  assign o_timeout = (STRETCH_TIMEOUT != 0) && i_active && (cnt == LIMIT);

endmodule

// File: rtl/i2c_rx_byte_controller.sv
// I2C master-side byte receiver: clocks in 8 bits MSB first, then drives
// ACK or NACK on the ninth SCL pulse. Aborts on a clock-stretch timeout.
module i2c_rx_byte_controller
  import i2c_pkg::*;
#(
  parameter int unsigned STRETCH_TIMEOUT = 1024,
  parameter int unsigned TIMEOUT_W       = 11
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  i2c_rx_byte_controller_if.slave  bus
);

  rx_state_e  state, state_n;
  step_e      step, step_n;
  logic [2:0] bit_cnt, bit_cnt_n;

  logic       ev_start, ev_sample, ev_byte, ev_done, ev_abort;
  logic       timeout, stretch_active, step_change;
  logic [7:0] shift;
  logic       ack_q;

  assign stretch_active = (state != ST_IDLE) && (step == STEP_HIGH);
  assign step_change    = (step_n != step);

  i2c_scl_stretch_monitor #(
    .STRETCH_TIMEOUT (STRETCH_TIMEOUT),
    .TIMEOUT_W       (TIMEOUT_W)
  ) u_stretch (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_tick    (bus.i_tick),
    .i_active  (stretch_active),
    .i_clear   (step_change),
    .i_scl     (bus.i_scl),
    .o_timeout (timeout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      step    <= STEP_RISE;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      step    <= step_n;
      bit_cnt <= bit_cnt_n;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    step_n    = step;
    bit_cnt_n = bit_cnt;
    ev_start  = 1'b0;
    ev_sample = 1'b0;
    ev_byte   = 1'b0;
    ev_done   = 1'b0;
    ev_abort  = 1'b0;

    if (state == ST_IDLE) begin
      if (bus.i_rx_start) begin
        state_n   = ST_DATA;
        step_n    = STEP_RISE;
        bit_cnt_n = '0;
        ev_start  = 1'b1;
      end
    end else if (timeout) begin
      state_n   = ST_IDLE;
      step_n    = STEP_RISE;
      bit_cnt_n = '0;
      ev_abort  = 1'b1;
    end else if (bus.i_tick) begin
      case (step)
        STEP_RISE: step_n = STEP_HIGH;
        // Holding here while SCL reads low is what honours stretching.
        STEP_HIGH: if (bus.i_scl) step_n = STEP_FALL;
        STEP_FALL: begin
          step_n    = STEP_LOW;
          ev_sample = (state == ST_DATA);
        end
        default: begin
          step_n = STEP_RISE;
          if (state == ST_ACK) begin
            state_n = ST_IDLE;
            ev_done = 1'b1;
          end else if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
            state_n   = ST_ACK;
            bit_cnt_n = '0;
            ev_byte   = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.o_busy        = (state != ST_IDLE);
    bus.o_scl_disable = 1'b0;
    bus.o_sda_disable = 1'b1;
    case (state)
      ST_DATA: bus.o_scl_disable = scl_released(step);
      ST_ACK: begin
        bus.o_scl_disable = scl_released(step);
        bus.o_sda_disable = !ack_q;
      end
      default: ;
    endcase
  end

  // Open-drain lines: the only value ever driven is low.
  assign bus.o_sda = 1'b0;
  assign bus.o_scl = 1'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift          <= '0;
      ack_q          <= 1'b0;
      bus.o_rx_data  <= '0;
      bus.o_rx_valid <= 1'b0;
      bus.o_rx_done  <= 1'b0;
      bus.o_rx_error <= 1'b0;
    end else begin
      bus.o_rx_valid <= ev_byte;
      bus.o_rx_done  <= ev_done;
      bus.o_rx_error <= ev_abort;
      if (ev_start) begin
        ack_q <= bus.i_ack_send;
        shift <= '0;
      end
      if (ev_sample) shift <= {shift[6:0], bus.i_sda};
      if (ev_byte)   bus.o_rx_data <= shift;
    end
  end

endmodule

// File: tb/tb_i2c_rx_byte_controller.sv
// Directed bench for i2c_rx_byte_controller with a simple open-drain slave
// model that shifts out a byte and can stretch SCL on a chosen bit.
module tb_i2c_rx_byte_controller;

  localparam int BUDGET = 4000;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    int         sbit;
    int         sticks;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         n_valid;
    int         n_done;
    int         n_err;
    int         pulses;
    logic       coincide;
    logic       sda9;
    logic       done_tick;
    logic       busy_end;
    logic       scl_dis_end;
    logic       sda_dis_end;
    logic       timed_out;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_rx_byte_controller_if bus ();

  i2c_rx_byte_controller #(
    .STRETCH_TIMEOUT (1024),
    .TIMEOUT_W       (11)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model state
  logic [7:0] slave_byte = 8'hFF;
  int   fall_cnt = 0;
  int   base = 0;
  int   hold_rem = 0;
  int   stretch_bit = 0;
  int   stretch_ticks = 0;
  int   stretch_tag = 0;
  int   stretch_done_tag = 0;
  logic tick_prev = 1'b0;
  logic scl_dis_prev = 1'b0;
  int   tick_div = 0;
  logic slave_sda;

  always_comb begin
    int idx;
    idx = 7 - (fall_cnt - base);
    slave_sda = (idx >= 0 && idx <= 7) ? slave_byte[idx[2:0]] : 1'b1;
  end

  assign bus.i_sda = bus.o_sda_disable ? slave_sda : (bus.o_sda & slave_sda);
  assign bus.i_scl = (bus.o_scl_disable ? 1'b1 : bus.o_scl) & (hold_rem == 0);

  // Tick generator and slave stretch behaviour, updated on the falling edge.
  initial begin
    bus.i_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_prev = bus.i_tick;
      if (bus.i_tick && hold_rem > 0) hold_rem--;
      if (!bus.o_scl_disable) hold_rem = 0;
      if (scl_dis_prev && !bus.o_scl_disable) fall_cnt++;
      scl_dis_prev = bus.o_scl_disable;
      if (stretch_tag != stretch_done_tag && bus.o_scl_disable && hold_rem == 0 &&
          (fall_cnt - base) == stretch_bit) begin
        hold_rem = stretch_ticks;
        stretch_done_tag = stretch_tag;
      end
      tick_div = (tick_div + 1) % 2;
      bus.i_tick = (tick_div == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic start_byte(input logic [7:0] data, input logic ack,
                            input int sbit, input int sticks);
    slave_byte    = data;
    base          = fall_cnt;
    stretch_bit   = sbit;
    stretch_ticks = sticks;
    if (sticks > 0) stretch_tag++;
    bus.i_ack_send = ack;
    bus.i_rx_start = 1'b1;
    cyc();
    bus.i_rx_start = 1'b0;
  endtask

  task automatic watch_byte(input int repulse_at, output res_t r);
    logic scl_prev;
    bit   fin;
    scl_prev = 1'b0;
    fin = 1'b0;
    r.data = 8'h00; r.n_valid = 0; r.n_done = 0; r.n_err = 0; r.pulses = 0;
    r.coincide = 1'b0; r.sda9 = 1'b1; r.done_tick = 1'b0; r.busy_end = 1'b1;
    r.scl_dis_end = 1'b1; r.sda_dis_end = 1'b0;
    for (int c = 0; c < BUDGET && !fin; c++) begin
      bus.i_rx_start = (c == repulse_at);
      cyc();
      if (bus.i_scl && !scl_prev) r.pulses++;
      scl_prev = bus.i_scl;
      if (r.pulses == 9 && bus.i_scl) r.sda9 = r.sda9 & bus.i_sda;
      if (bus.o_rx_valid) begin
        r.n_valid++;
        r.data = bus.o_rx_data;
      end
      if (bus.o_rx_valid && bus.o_rx_done) r.coincide = 1'b1;
      if (bus.o_rx_done) begin
        r.n_done++;
        r.done_tick = tick_prev;
      end
      if (bus.o_rx_error) r.n_err++;
      if (bus.o_rx_done || bus.o_rx_error) begin
        fin = 1'b1;
        r.busy_end    = bus.o_busy;
        r.scl_dis_end = bus.o_scl_disable;
        r.sda_dis_end = bus.o_sda_disable;
      end
    end
    bus.i_rx_start = 1'b0;
    r.timed_out = !fin;
  endtask

  task automatic check_good(input string tag, input res_t r, input logic [7:0] exp_data,
                            input logic ack);
    check({tag, "_timeout"}, 32'(r.timed_out), 32'd0);
    check({tag, "_data"}, 32'(r.data), 32'(exp_data));
    check({tag, "_valid_cnt"}, 32'(r.n_valid), 32'd1);
    check({tag, "_done_cnt"}, 32'(r.n_done), 32'd1);
    check({tag, "_err_cnt"}, 32'(r.n_err), 32'd0);
    check({tag, "_pulses"}, 32'(r.pulses), 32'd9);
    check({tag, "_sda9"}, 32'(r.sda9), 32'(!ack));
    check({tag, "_done_after_tick"}, 32'(r.done_tick), 32'd1);
    check({tag, "_coincide"}, 32'(r.coincide), 32'd0);
    check({tag, "_busy_end"}, 32'(r.busy_end), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.o_rx_valid), 32'd0);
    check({tag, "_done"}, 32'(bus.o_rx_done), 32'd0);
    check({tag, "_err"}, 32'(bus.o_rx_error), 32'd0);
    check({tag, "_data"}, 32'(bus.o_rx_data), 32'd0);
    check({tag, "_scl_dis"}, 32'(bus.o_scl_disable), 32'd0);
    check({tag, "_sda_dis"}, 32'(bus.o_sda_disable), 32'd1);
    check({tag, "_scl"}, 32'(bus.o_scl), 32'd0);
    check({tag, "_sda"}, 32'(bus.o_sda), 32'd0);
  endtask

  vec_t vecs[5];
  res_t r;

  initial begin
    bit hit;
    vecs[0] = '{data: 8'hA5, ack: 1'b1, sbit: 0, sticks: 0,    exp_err: 1'b0, exp_data: 8'hA5};
    vecs[1] = '{data: 8'h3C, ack: 1'b0, sbit: 0, sticks: 0,    exp_err: 1'b0, exp_data: 8'h3C};
    vecs[2] = '{data: 8'h81, ack: 1'b1, sbit: 3, sticks: 50,   exp_err: 1'b0, exp_data: 8'h81};
    // Held well past the 1024-tick limit on bit 2; previous byte stays on o_rx_data.
    vecs[3] = '{data: 8'hC3, ack: 1'b1, sbit: 2, sticks: 1100, exp_err: 1'b1, exp_data: 8'h81};
    vecs[4] = '{data: 8'h96, ack: 1'b0, sbit: 0, sticks: 0,    exp_err: 1'b0, exp_data: 8'h96};

    bus.i_rx_start = 1'b0;
    bus.i_ack_send = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc();
    check_reset_vals("reset");

    rst_n = 1'b1;
    repeat (10) cyc();
    check("idle_ticks_busy", 32'(bus.o_busy), 32'd0);
    check("idle_ticks_scl_dis", 32'(bus.o_scl_disable), 32'd0);

    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_byte(vecs[i].data, vecs[i].ack, vecs[i].sbit, vecs[i].sticks);
      check({tag, "_busy_start"}, 32'(bus.o_busy), 32'd1);
      watch_byte(-1, r);
      if (!vecs[i].exp_err) begin
        check_good(tag, r, vecs[i].exp_data, vecs[i].ack);
      end else begin
        check({tag, "_timeout"}, 32'(r.timed_out), 32'd0);
        check({tag, "_err_cnt"}, 32'(r.n_err), 32'd1);
        check({tag, "_valid_cnt"}, 32'(r.n_valid), 32'd0);
        check({tag, "_done_cnt"}, 32'(r.n_done), 32'd0);
        check({tag, "_busy_end"}, 32'(r.busy_end), 32'd0);
        check({tag, "_scl_dis_end"}, 32'(r.scl_dis_end), 32'd0);
        check({tag, "_sda_dis_end"}, 32'(r.sda_dis_end), 32'd1);
      end
      check({tag, "_held_data"}, 32'(bus.o_rx_data), 32'(vecs[i].exp_data));
      repeat (4) cyc();
    end

    // Reset asserted in the middle of bit 5.
    start_byte(8'hE7, 1'b1, 0, 0);
    hit = 1'b0;
    for (int c = 0; c < BUDGET && !hit; c++) begin
      cyc();
      if ((fall_cnt - base) == 5) hit = 1'b1;
    end
    check("midrst_reached_bit5", 32'(hit), 32'd1);
    check("midrst_busy_before", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    start_byte(8'h5A, 1'b1, 0, 0);
    watch_byte(-1, r);
    check_good("after_rst", r, 8'h5A, 1'b1);
    repeat (4) cyc();

    // Start re-pulsed mid-byte, then a new start on the done cycle.
    start_byte(8'hFF, 1'b0, 0, 0);
    watch_byte(20, r);
    check_good("repulse", r, 8'hFF, 1'b0);
    start_byte(8'h00, 1'b1, 0, 0);
    check("b2b_busy_start", 32'(bus.o_busy), 32'd1);
    watch_byte(-1, r);
    check_good("b2b", r, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
